click_region_detect: RTL and testbench

CLICK_REGION_DETECT -- requirements
Module: click_region_detect

---
 rtl/click_region_detect.sv | 219 +++++++++++++++++++++
 tb/tb_click_region_detect.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/click_region_detect.sv
// -----------------------------------------------------------------------------
// click_region_detect
//   Detects mouse clicks on a grid of rectangular tiles. The raw left-button
//   level is synchronised and debounced. The cursor position is decoded into
//   a tile index. A click is reported only when the button is pressed and
//   released over the same tile.
//
// Ports
//   clk          in   1   system clock (the only clock)
//   rst          in   1   asynchronous active-high reset
//   MouseLeft    in   1   raw left-button level, asynchronous to clk
//   xpos         in  12   cursor x in pixels
//   ypos         in  12   cursor y in pixels
//   hover_valid  out  1   cursor is inside a tile (registered)
//   hover_idx    out  3   tile under cursor, row*COLS+col; 0 when not hovering
//   click_valid  out  1   one-cycle pulse for a completed click on a tile
//   click_idx    out  3   index of the last clicked tile (held between clicks)
// -----------------------------------------------------------------------------
module click_region_detect #(
    parameter int X_ORIGIN   = 64,
    parameter int Y_ORIGIN   = 48,
    parameter int TILE_W     = 128,
    parameter int TILE_H     = 160,
    parameter int PITCH_X    = 160,
    parameter int PITCH_Y    = 200,
    parameter int COLS       = 4,
    parameter int ROWS       = 2,
    parameter int DEB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MouseLeft,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic        hover_valid,
    output logic [2:0]  hover_idx,
    output logic        click_valid,
    output logic [2:0]  click_idx
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    // Tile membership test; 13-bit unsigned arithmetic keeps the inclusive
    // right/bottom edges from wrapping for any 12-bit cursor value.
    function automatic logic in_tile(input logic [12:0] x, input logic [12:0] y,
                                     input int c, input int r);
        logic [12:0] left;
        logic [12:0] top;
        left = 13'(X_ORIGIN + c * PITCH_X);
        top  = 13'(Y_ORIGIN + r * PITCH_Y);
        return (x >= left) && (x <= (left + 13'(TILE_W))) &&
               (y >= top)  && (y <= (top + 13'(TILE_H)));
    endfunction

    logic             r_sync1;
    logic             r_sync2;
    logic             r_btn_stable;
    logic             r_btn_prev;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_press_idx;
    logic [2:0]       w_press_idx_nxt;
    logic             w_click_pulse;
    logic             r_hover_valid;
    logic [2:0]       r_hover_idx;
    logic             r_click_valid;
    logic [2:0]       r_click_idx;
    logic             w_hit;
    logic [2:0]       w_hit_idx;
    logic             w_rise;
    logic             w_fall;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= MouseLeft;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: accept a new level only after it has been stable long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_stable <= 1'b0;
            r_cnt        <= {CNT_W{1'b0}};
        end else if (r_sync2 != r_btn_stable) begin
            if (r_cnt == CNT_LAST) begin
                r_btn_stable <= r_sync2;
                r_cnt        <= {CNT_W{1'b0}};
            end else begin
                r_btn_stable <= r_btn_stable;
                r_cnt        <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_btn_stable <= r_btn_stable;
            r_cnt        <= {CNT_W{1'b0}};
        end
    end

    // Delayed copy of the debounced level, used to find its edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_prev <= 1'b0;
        end else begin
            r_btn_prev <= r_btn_stable;
        end
    end

    assign w_rise = r_btn_stable & ~r_btn_prev;
    assign w_fall = ~r_btn_stable & r_btn_prev;

    // Region decode: first tile (row-major) containing the cursor wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 3'd0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!w_hit && in_tile({1'b0, xpos}, {1'b0, ypos}, c, r)) begin
                    w_hit     = 1'b1;
                    w_hit_idx = 3'(r * COLS + c);
                end else begin
                    w_hit     = w_hit;
                    w_hit_idx = w_hit_idx;
                end
            end
        end
    end

    // Hover registers track the decode every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hover_valid <= 1'b0;
            r_hover_idx   <= 3'd0;
        end else begin
            r_hover_valid <= w_hit;
            r_hover_idx   <= w_hit_idx;
        end
    end

    // Click FSM state register plus the registers it updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_press_idx   <= 3'd0;
            r_click_valid <= 1'b0;
            r_click_idx   <= 3'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_press_idx   <= w_press_idx_nxt;
            r_click_valid <= w_click_pulse;
            if (w_click_pulse) begin
                r_click_idx <= r_press_idx;
            end else begin
                r_click_idx <= r_click_idx;
            end
        end
    end

    // Click FSM next-state logic. A press that starts off-tile goes to
    // BLOCKED so that sliding onto a tile while held can never arm a click.
    always_comb begin
        w_state_nxt     = r_state;
        w_press_idx_nxt = r_press_idx;
        w_click_pulse   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    if (r_hover_valid) begin
                        w_state_nxt     = ST_PRESSED;
                        w_press_idx_nxt = r_hover_idx;
                    end else begin
                        w_state_nxt = ST_BLOCKED;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                    if (r_hover_valid && (r_hover_idx == r_press_idx)) begin
                        w_click_pulse = 1'b1;
                    end else begin
                        w_click_pulse = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_PRESSED;
                end
            end
            ST_BLOCKED: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BLOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign hover_valid = r_hover_valid;
    assign hover_idx   = r_hover_idx;
    assign click_valid = r_click_valid;
    assign click_idx   = r_click_idx;

endmodule

// File: tb/tb_click_region_detect.sv
// -----------------------------------------------------------------------------
// tb_click_region_detect
//   Directed bench for click_region_detect with DEB_CYCLES=4. Expected clicks
//   (tile index and sampling cycle) are queued when a release is driven. A
//   monitor pops and compares them whenever click_valid is seen high.
// -----------------------------------------------------------------------------
module tb_click_region_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        MouseLeft;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        hover_valid;
    logic [2:0]  hover_idx;
    logic        click_valid;
    logic [2:0]  click_idx;

    typedef struct {
        logic [2:0] idx;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic prev_cv = 1'b0;

    click_region_detect #(.DEB_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .MouseLeft  (MouseLeft),
        .xpos       (xpos),
        .ypos       (ypos),
        .hover_valid(hover_valid),
        .hover_idx  (hover_idx),
        .click_valid(click_valid),
        .click_idx  (click_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cursor(input int x, input int y);
        xpos = 12'(x);
        ypos = 12'(y);
    endtask

    // Release at the current negedge; pulse is expected DEB+3 = 7 edges later.
    task automatic release_expect(input logic [2:0] idx);
        exp_t e;
        MouseLeft = 1'b0;
        e.idx = idx;
        e.cyc = cyc + 7;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        if (click_valid === 1'b1) begin
            n_cmp++;
            assert (prev_cv === 1'b0) else begin
                n_err++;
                $error("FAIL click_consecutive: observed %0d expected %0d", prev_cv, 1'b0);
            end
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL click_unexpected: observed pulse idx %0d at cycle %0d expected none",
                       click_idx, cyc);
            end
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                assert (click_idx === e.idx) else begin
                    n_err++;
                    $error("FAIL click_idx: observed %0d expected %0d", click_idx, e.idx);
                end
                n_cmp++;
                assert (cyc === e.cyc) else begin
                    n_err++;
                    $error("FAIL click_cycle: observed %0d expected %0d", cyc, e.cyc);
                end
            end
        end
        prev_cv = click_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        MouseLeft = 1'b0;
        set_cursor(100, 100);
        wait_cyc(3);
        chk("rst_hover_valid", 32'(hover_valid), 32'd0);
        chk("rst_hover_idx",   32'(hover_idx),   32'd0);
        chk("rst_click_valid", 32'(click_valid), 32'd0);
        chk("rst_click_idx",   32'(click_idx),   32'd0);
        rst = 1'b0;
        wait_cyc(2);

        // Basic click on tile 0 with debounce latency checks.
        chk("hover_t0_valid", 32'(hover_valid), 32'd1);
        chk("hover_t0_idx",   32'(hover_idx),   32'd0);
        MouseLeft = 1'b1;
        wait_cyc(5);
        chk("btn_stable_edge5", 32'(dut.r_btn_stable), 32'd0);
        wait_cyc(1);
        chk("btn_stable_edge6", 32'(dut.r_btn_stable), 32'd1);
        wait_cyc(14);
        release_expect(3'd0);
        wait_cyc(12);
        chk("click_idx_t0", 32'(click_idx), 32'd0);

        // Hover decode including gaps and inclusive edges.
        set_cursor(544, 300); wait_cyc(1);
        chk("hover_544_300_v", 32'(hover_valid), 32'd1);
        chk("hover_544_300_i", 32'(hover_idx),   32'd7);
        set_cursor(200, 100); wait_cyc(1);
        chk("hover_gap_v", 32'(hover_valid), 32'd0);
        chk("hover_gap_i", 32'(hover_idx),   32'd0);
        set_cursor(192, 48); wait_cyc(1);
        chk("hover_192_48_v", 32'(hover_valid), 32'd1);
        chk("hover_192_48_i", 32'(hover_idx),   32'd0);
        set_cursor(193, 48); wait_cyc(1);
        chk("hover_193_48_v", 32'(hover_valid), 32'd0);
        set_cursor(64, 47); wait_cyc(1);
        chk("hover_64_47_v", 32'(hover_valid), 32'd0);
        set_cursor(672, 408); wait_cyc(1);
        chk("hover_672_408_v", 32'(hover_valid), 32'd1);
        chk("hover_672_408_i", 32'(hover_idx),   32'd7);
        set_cursor(4000, 4000); wait_cyc(1);
        chk("hover_far_v", 32'(hover_valid), 32'd0);

        // Click on tile 5 so click_idx carries a non-zero value.
        set_cursor(250, 300); wait_cyc(2);
        MouseLeft = 1'b1; wait_cyc(10);
        release_expect(3'd5);
        wait_cyc(12);
        chk("click_idx_t5", 32'(click_idx), 32'd5);

        // Press on tile 1, release on tile 2: no click.
        set_cursor(250, 100); wait_cyc(2);
        MouseLeft = 1'b1; wait_cyc(10);
        set_cursor(400, 100); wait_cyc(2);
        MouseLeft = 1'b0; wait_cyc(12);

        // Press in a gap, slide onto tile 0, release: no click.
        set_cursor(200, 100); wait_cyc(2);
        MouseLeft = 1'b1; wait_cyc(10);
        set_cursor(100, 100); wait_cyc(10);
        MouseLeft = 1'b0; wait_cyc(12);

        // Three-cycle glitch must be rejected.
        MouseLeft = 1'b1; wait_cyc(3);
        MouseLeft = 1'b0; wait_cyc(10);
        chk("glitch_btn_stable", 32'(dut.r_btn_stable), 32'd0);
        chk("glitch_click_idx",  32'(click_idx),        32'd5);

        // Reset while PRESSED on tile 3 discards the press.
        set_cursor(600, 100); wait_cyc(2);
        MouseLeft = 1'b1; wait_cyc(10);
        rst = 1'b1; #1;
        chk("midrst_hover_valid", 32'(hover_valid), 32'd0);
        chk("midrst_hover_idx",   32'(hover_idx),   32'd0);
        chk("midrst_click_valid", 32'(click_valid), 32'd0);
        chk("midrst_click_idx",   32'(click_idx),   32'd0);
        wait_cyc(2);
        MouseLeft = 1'b0; wait_cyc(2);
        rst = 1'b0; wait_cyc(15);
        chk("postrst_click_idx", 32'(click_idx), 32'd0);

        // Full click on tile 3 after reset.
        MouseLeft = 1'b1; wait_cyc(10);
        release_expect(3'd3);
        wait_cyc(12);
        chk("click_idx_t3", 32'(click_idx), 32'd3);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
